glitch_sequencer: RTL and testbench

Timing front-end for the clock-glitch path: arms on command, waits for a rising edge on an external trigger, counts a programmable delay, then emits a burst of `glitch_en` pulses of programmable width, gap and count. It drives the `en`/`mode` inputs of the clock-glitch multiplexer directly downstream. All outputs are registered so the mux select never glitches.

---
 rtl/glitch_sequencer_if.sv | 45 ++++
 rtl/glitch_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sequencer_if.sv
// ----------------------------------------------------------------------------
// glitch_sequencer_if
//   Control, configuration and status bundle of the clock-glitch timing
//   front-end.
//   master : drives arm/abort/trigger and the cfg_* fields, observes status.
//   slave  : the sequencer itself; observes control/config, drives the
//            registered glitch mux controls and status flags.
//   Signals:
//     arm, abort, trigger        control inputs to the sequencer
//     cfg_mode[7:0]              glitch mode latched on arm
//     cfg_delay/width/gap[CNT_W] timing configuration latched on arm
//     cfg_repeat[REP_W]          pulse count latched on arm
//     glitch_en, glitch_mode     registered glitch mux controls
//     armed, busy, done          registered status
// ----------------------------------------------------------------------------
interface glitch_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
);
    logic             arm;
    logic             abort;
    logic             trigger;
    logic [7:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [REP_W-1:0] cfg_repeat;
    logic             glitch_en;
    logic [7:0]       glitch_mode;
    logic             armed;
    logic             busy;
    logic             done;

    modport master (
        output arm, abort, trigger,
        output cfg_mode, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
        input  glitch_en, glitch_mode, armed, busy, done
    );

    modport slave (
        input  arm, abort, trigger,
        input  cfg_mode, cfg_delay, cfg_width, cfg_gap, cfg_repeat,
        output glitch_en, glitch_mode, armed, busy, done
    );
endinterface

// File: rtl/glitch_sequencer.sv
// ----------------------------------------------------------------------------
// glitch_sequencer
//   Timing front-end for the clock-glitch path. Arms on command, waits for a
//   synchronised rising edge on the external trigger, counts a programmable
//   delay, then emits a burst of glitch_en pulses of programmable width, gap
//   and count. Every output is a flop so the downstream mux select is clean.
//   Ports:
//     clk_in : system clock, all logic on its rising edge
//     rst    : synchronous reset, active-high
//     bus    : glitch_sequencer_if.slave (control, config, mux controls,
//              status)
// ----------------------------------------------------------------------------
module glitch_sequencer #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    glitch_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        GLITCH,
        GAP
    } state_t;

    state_t           state_q, state_d;

    // Three-flop trigger synchroniser; s3 is the previous synchronised value.
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             trig_edge;

    // Shadow copies of the configuration, held for the whole burst. Width,
    // gap and repeat are stored already mapped 0 -> 1.
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q,   gap_d;
    logic [REP_W-1:0] repeat_q, repeat_d;

    // cnt counts remaining cycles of the current phase minus one;
    // rep counts pulses still to be started after the current one.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;

    logic             glitch_en_q, glitch_en_d;
    logic [7:0]       mode_q, mode_d;
    logic             armed_q, armed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign trig_edge = s2_q & ~s3_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        s1_d        = bus.trigger;
        s2_d        = s1_q;
        s3_d        = s2_q;
        delay_d     = delay_q;
        width_d     = width_q;
        gap_d       = gap_q;
        repeat_d    = repeat_q;
        cnt_d       = cnt_q;
        rep_d       = rep_q;
        glitch_en_d = glitch_en_q;
        mode_d      = mode_q;
        armed_d     = armed_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (bus.abort) begin
            // Mode is left alone; it is harmless while the enable is low.
            state_d     = IDLE;
            glitch_en_d = 1'b0;
            armed_d     = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        delay_d  = bus.cfg_delay;
                        width_d  = (bus.cfg_width  == '0) ? CNT_W'(1) : bus.cfg_width;
                        gap_d    = (bus.cfg_gap    == '0) ? CNT_W'(1) : bus.cfg_gap;
                        repeat_d = (bus.cfg_repeat == '0) ? REP_W'(1) : bus.cfg_repeat;
                        mode_d   = bus.cfg_mode;
                        armed_d  = 1'b1;
                        state_d  = ARMED;
                    end
                end

                ARMED: begin
                    if (trig_edge) begin
                        armed_d = 1'b0;
                        busy_d  = 1'b1;
                        if (delay_q == '0) begin
                            state_d     = GLITCH;
                            glitch_en_d = 1'b1;
                            cnt_d       = width_q - CNT_W'(1);
                            rep_d       = repeat_q - REP_W'(1);
                        end else begin
                            state_d = DELAY;
                            cnt_d   = delay_q - CNT_W'(1);
                        end
                    end
                end

                DELAY: begin
                    if (cnt_q == '0) begin
                        state_d     = GLITCH;
                        glitch_en_d = 1'b1;
                        cnt_d       = width_q - CNT_W'(1);
                        rep_d       = repeat_q - REP_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                GLITCH: begin
                    if (cnt_q == '0) begin
                        glitch_en_d = 1'b0;
                        if (rep_q == '0) begin
                            // Last pulse: done coincides with the falling enable.
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = gap_q - CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt_q == '0) begin
                        state_d     = GLITCH;
                        glitch_en_d = 1'b1;
                        cnt_d       = width_q - CNT_W'(1);
                        rep_d       = rep_q - REP_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_d     = IDLE;
                    glitch_en_d = 1'b0;
                    armed_d     = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            delay_q     <= '0;
            width_q     <= '0;
            gap_q       <= '0;
            repeat_q    <= '0;
            cnt_q       <= '0;
            rep_q       <= '0;
            glitch_en_q <= 1'b0;
            mode_q      <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            repeat_q    <= repeat_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            glitch_en_q <= glitch_en_d;
            mode_q      <= mode_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.glitch_en   = glitch_en_q;
    assign bus.glitch_mode = mode_q;
    assign bus.armed       = armed_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_glitch_sequencer
//   Directed bench for glitch_sequencer. Edges are numbered from E0, the
//   rising clock edge at which the trigger is first sampled high; outputs are
//   sampled 1 time unit after each rising edge ("after Ek").
// ----------------------------------------------------------------------------
module tb_glitch_sequencer;

    localparam int CNT_W = 16;
    localparam int REP_W = 8;

    logic clk_in = 1'b0;
    logic rst;

    always #5 clk_in = ~clk_in;

    glitch_sequencer_if #(.CNT_W(CNT_W), .REP_W(REP_W)) bus ();

    glitch_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},    bus.glitch_en, 1'b0);
        check({tag, "_armed"}, bus.armed,     1'b0);
        check({tag, "_busy"},  bus.busy,      1'b0);
        check({tag, "_done"},  bus.done,      1'b0);
    endtask

    task automatic do_arm(input logic [7:0] mode, input int d, input int w,
                          input int g, input int r);
        bus.cfg_mode   = mode;
        bus.cfg_delay  = CNT_W'(d);
        bus.cfg_width  = CNT_W'(w);
        bus.cfg_gap    = CNT_W'(g);
        bus.cfg_repeat = REP_W'(r);
        bus.arm        = 1'b1;
        tick();
        bus.arm        = 1'b0;
        check("arm_armed", bus.armed, 1'b1);
        check("arm_busy",  bus.busy,  1'b0);
    endtask

    // Drives a trigger edge at E0 and checks a whole burst. d/w/g/r are the
    // effective values the burst must show; wiggle adds trigger edges after E2.
    task automatic run_burst(input string name, input int d, input int w, input int g,
                             input int r, input logic [7:0] mode, input bit wiggle);
        int  done_k;
        int  t;
        bit  exp_en;
        done_k = 2 + d + (r - 1) * (w + g) + w;
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= done_k; k++) begin
            if (wiggle && k >= 2) bus.trigger = ~k[0];
            else                  bus.trigger = 1'b0;
            tick();
            t      = k - (2 + d);
            exp_en = (t >= 0) && ((t % (w + g)) < w) && ((t / (w + g)) < r);
            check($sformatf("%s_en@E%0d",    name, k), bus.glitch_en,   exp_en);
            check($sformatf("%s_done@E%0d",  name, k), bus.done,        k == done_k);
            check($sformatf("%s_busy@E%0d",  name, k), bus.busy,        (k >= 2) && (k < done_k));
            check($sformatf("%s_armed@E%0d", name, k), bus.armed,       k < 2);
            check($sformatf("%s_mode@E%0d",  name, k), bus.glitch_mode, mode);
        end
        bus.trigger = 1'b0;
        tick();
        check_quiet({name, "_after"});
    endtask

    initial begin
        logic [11:0] basic_en;
        logic [11:0] basic_done;
        logic [11:0] basic_busy;

        rst            = 1'b1;
        bus.arm        = 1'b1;
        bus.abort      = 1'b0;
        bus.trigger    = 1'b0;
        bus.cfg_mode   = 8'h5A;
        bus.cfg_delay  = '0;
        bus.cfg_width  = '0;
        bus.cfg_gap    = '0;
        bus.cfg_repeat = '0;

        // Reset overrides a pending arm.
        idle(3);
        check_quiet("reset");
        check("reset_mode", bus.glitch_mode, 8'h00);
        bus.arm = 1'b0;
        rst     = 1'b0;

        // Trigger toggling without arm never produces a pulse.
        for (int i = 0; i < 8; i++) begin
            bus.trigger = (i % 3) != 2;
            tick();
            check($sformatf("noarm_en@%0d", i),    bus.glitch_en, 1'b0);
            check($sformatf("noarm_armed@%0d", i), bus.armed,     1'b0);
        end
        bus.trigger = 1'b0;
        idle(3);

        // abort together with arm in IDLE stays in IDLE.
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        check_quiet("arm_abort");

        // Basic burst: delay 3, width 2, gap 1, repeat 2, hand-written timeline.
        basic_en   = 12'h360;   // high after E5, E6, E8, E9
        basic_done = 12'h400;   // only after E10
        basic_busy = 12'h3FC;   // after E2 .. E9
        do_arm(8'h08, 3, 2, 1, 2);
        bus.trigger = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            bus.trigger = 1'b0;
            tick();
            check($sformatf("basic_en@E%0d", k),    bus.glitch_en,   basic_en[k]);
            check($sformatf("basic_done@E%0d", k),  bus.done,        basic_done[k]);
            check($sformatf("basic_busy@E%0d", k),  bus.busy,        basic_busy[k]);
            check($sformatf("basic_armed@E%0d", k), bus.armed,       k == 1);
            check($sformatf("basic_mode@E%0d", k),  bus.glitch_mode, 8'h08);
        end
        // New arm accepted while done is high.
        do_arm(8'h09, 1, 1, 1, 1);
        check("rearm_done_clear", bus.done, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_quiet("rearm_abort");
        check("rearm_mode_held", bus.glitch_mode, 8'h09);
        idle(2);

        // All-zero config: a single one-cycle pulse at E2, done after E3.
        do_arm(8'h0A, 0, 0, 0, 0);
        run_burst("zero", 0, 1, 1, 1, 8'h0A, 1'b0);

        // Trigger already high at arm time must not fire.
        bus.trigger = 1'b1;
        idle(4);
        do_arm(8'h11, 2, 3, 2, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("level_en@%0d", i),    bus.glitch_en, 1'b0);
            check($sformatf("level_armed@%0d", i), bus.armed,     1'b1);
        end
        bus.trigger = 1'b0;
        idle(3);
        run_burst("level", 2, 3, 2, 3, 8'h11, 1'b0);

        // Extra trigger edges during DELAY and GAP leave timing unchanged.
        do_arm(8'h05, 3, 2, 3, 3);
        run_burst("wiggle", 3, 2, 3, 3, 8'h05, 1'b1);
        idle(3);

        // Abort on the 4th high cycle of a 10-cycle pulse.
        do_arm(8'h20, 0, 10, 1, 2);
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        idle(5);
        check("abort_pre_en", bus.glitch_en, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_quiet("abort");
        check("abort_mode_held", bus.glitch_mode, 8'h20);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("abort_en@%0d", i),   bus.glitch_en, 1'b0);
            check($sformatf("abort_done@%0d", i), bus.done,      1'b0);
        end
        do_arm(8'h20, 0, 10, 1, 2);
        run_burst("abort_rerun", 0, 10, 1, 2, 8'h20, 1'b0);

        // Config changes after arm are ignored.
        do_arm(8'h33, 3, 2, 2, 2);
        bus.cfg_delay  = 16'd50;
        bus.cfg_width  = 16'd9;
        bus.cfg_gap    = 16'd7;
        bus.cfg_repeat = 8'd6;
        bus.cfg_mode   = 8'hFF;
        run_burst("iso", 3, 2, 2, 2, 8'h33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
